// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: run-mode state encoding and default pacing constants for pc_run_ctrl.
package pc_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_SLOW = 2'd1,
        RUN_FAST = 2'd2,
        HALTED   = 2'd3
    } run_state_t;
    localparam int SLOW_DIV_DEF   = 50_000_000;
    localparam int FAST_DIV_DEF   = 500_000;
    localparam int DEB_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/btn_cond.sv
// btn_cond: synchronizes and debounces a raw button, pulsing evt once per accepted press.
module btn_cond
    import pc_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic evt
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;
    // The level flips only after DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            deb  <= 1'b0;
            cnt  <= '0;
            evt  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            evt  <= 1'b0;
            if (sync[1] == deb) cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt <= '0;
                deb <= sync[1];
                evt <= sync[1];
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl: button-driven run/step controller producing step/load strobes for the program counter.
module pc_run_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int SLOW_DIV   = SLOW_DIV_DEF,
    parameter int FAST_DIV   = FAST_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_run,
    input  logic       btn_speedrun,
    input  logic       btn_stop,
    input  logic       mode,
    input  logic [7:0] jump_addr,
    input  logic       halt,
    output logic       pc_step,
    output logic       pc_load,
    output logic [7:0] load_value,
    output logic [1:0] run_state,
    output logic       running
);
    localparam int DW = $clog2(SLOW_DIV);
    run_state_t    state, state_n;
    logic [DW-1:0] div, div_n;
    logic          step_n, load_n, tick, in_run;
    logic          ev_next, ev_run, ev_speed, ev_stop;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_next  (.clk(clk), .rst_n(rst_n), .btn(btn_next),     .evt(ev_next));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_run   (.clk(clk), .rst_n(rst_n), .btn(btn_run),      .evt(ev_run));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_speed (.clk(clk), .rst_n(rst_n), .btn(btn_speedrun), .evt(ev_speed));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_stop  (.clk(clk), .rst_n(rst_n), .btn(btn_stop),     .evt(ev_stop));

    assign in_run    = state == RUN_SLOW || state == RUN_FAST;
    assign tick      = in_run && div == (state == RUN_FAST ? DW'(FAST_DIV - 1) : DW'(SLOW_DIV - 1));
    assign run_state = state;
    assign running   = in_run;

    always_comb begin
        state_n = state;
        step_n  = 1'b0;
        load_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ev_stop) state_n = IDLE;
                else if (ev_next) begin
                    load_n  = mode;
                    step_n  = !mode && !halt;
                    state_n = (!mode && halt) ? HALTED : IDLE;
                end else if (ev_speed) state_n = RUN_FAST;
                else if (ev_run) state_n = RUN_SLOW;
            end
            RUN_SLOW, RUN_FAST: begin
                if (ev_stop) state_n = IDLE;
                else if (tick && halt) state_n = HALTED;
                else begin
                    step_n = tick;
                    // Re-pressing the current mode maps back to the same state, so the divider keeps counting.
                    if (ev_speed) state_n = RUN_FAST;
                    else if (ev_run) state_n = RUN_SLOW;
                end
            end
            HALTED: begin
                if (ev_stop) state_n = IDLE;
                else if (ev_next && mode) begin
                    load_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        div_n = (state_n != state || !in_run || tick) ? '0 : div + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div        <= '0;
            pc_step    <= 1'b0;
            pc_load    <= 1'b0;
            load_value <= '0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            pc_step <= step_n;
            pc_load <= load_n;
            if (load_n) load_value <= jump_addr;
        end
    end
endmodule
